// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment front panel.
// Segment codes are {a,b,c,d,e,f,g}, active low (0 = segment lit).
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_HEX [0:15] = '{
    7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110,
    7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111,
    7'b000_0000, 7'b000_1100, 7'b000_1000, 7'b110_0000,
    7'b011_0001, 7'b100_0010, 7'b011_0000, 7'b011_1000
  };

  localparam seg_t SEG_BLANK = 7'b111_1111;
  localparam seg_t SEG_ZERO  = 7'b000_0001;

  // Hex nibble to active-low segment pattern.
  function automatic seg_t seg7_enc(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/seg7_disp_ctrl_if.sv
// Board-side panel bundle between the pins / CPU core and seg7_disp_ctrl.
//   master : drives run_en, step_btn, blank_lz, value; observes cpu_ce, hex_seg
//   slave  : the controller; drives cpu_ce and hex_seg
// Signalling: there is no valid/ready pair on this bundle. cpu_ce is a
// single-cycle strobe with no backpressure -- the core must advance exactly
// once for every cycle in which cpu_ce is high. hex_seg is a registered level
// that is always valid; value is sampled only when a snapshot is taken.
interface seg7_disp_ctrl_if #(
  parameter int NUM_DIGITS = 6
);
  logic                    run_en;
  logic                    step_btn;
  logic                    blank_lz;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    cpu_ce;
  logic [7*NUM_DIGITS-1:0] hex_seg;

  modport master (
    output run_en, step_btn, blank_lz, value,
    input  cpu_ce, hex_seg
  );

  modport slave (
    input  run_en, step_btn, blank_lz, value,
    output cpu_ce, hex_seg
  );
endinterface

// File: rtl/seg7_debounce.sv
// Step button conditioner: 2-FF synchroniser, counting debouncer and
// rising-edge pulse generator.
//   clk, rst : system clock, synchronous active-high reset
//   btn_i    : raw asynchronous bouncing button, active high
//   pulse_o  : one-cycle pulse when the accepted level goes 0 -> 1
module seg7_debounce #(
  parameter int DB_CYCLES = 1000000,
  parameter int DB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            pulse_q, pulse_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive synchronised samples that disagree with the
  // accepted level; any agreeing sample restarts it. On the DB_CYCLES-th
  // disagreeing sample the new level is taken and the pulse fires if it is a rise.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/seg7_disp_ctrl.sv
// N-digit 7-segment front panel controller with CPU pacing.
//   clk, rst : system clock, synchronous active-high reset
//   pnl      : panel bundle (slave side)
//     run_en   1 = free-run pacing from the divider, 0 = single-step from button
//     step_btn raw step push-button
//     blank_lz 1 = blank leading zero digits (digit 0 always shown)
//     value    value to display, digit 0 = least significant nibble
//     cpu_ce   one-cycle clock enable to the CPU core
//     hex_seg  digit k at [7k+6:7k], {a..g}, active low
// Latency: cpu_ce high in cycle T -> snapshot in T+1 -> hex_seg in T+2.
module seg7_disp_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DIV_MAX    = 25000000,
  parameter int DIV_W      = 25,
  parameter int DB_CYCLES  = 1000000,
  parameter int DB_W       = 20
) (
  input  logic             clk,
  input  logic             rst,
  seg7_disp_ctrl_if.slave  pnl
);

  // Run-mode divider: free-running, independent of run_en.
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick;

  assign tick  = (cnt_q == DIV_W'(DIV_MAX - 1));
  assign cnt_d = tick ? '0 : cnt_q + DIV_W'(1);

  logic step_pulse;

  seg7_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (pnl.step_btn),
    .pulse_o (step_pulse)
  );

  // Only the selected source reaches the register, so an event on the other
  // path is dropped and a run_en toggle cannot manufacture a pulse.
  logic ce_q, ce_d;
  assign ce_d = pnl.run_en ? tick : step_pulse;

  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  assign snap_d = ce_q ? pnl.value : snap_q;

  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_lsd
      assign hex_d[6:0] = seg7_enc(snap_q[3:0]);
    end else begin : g_upper
      // Blank when this nibble and every more significant one are zero.
      logic upper_zero;
      assign upper_zero = (snap_q[4*NUM_DIGITS-1:4*k] == '0);
      assign hex_d[7*k +: 7] = (pnl.blank_lz && upper_zero) ? SEG_BLANK
                                                           : seg7_enc(snap_q[4*k +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      ce_q   <= 1'b0;
      snap_q <= '0;
      hex_q  <= {NUM_DIGITS{SEG_ZERO}};
    end else begin
      cnt_q  <= cnt_d;
      ce_q   <= ce_d;
      snap_q <= snap_d;
      hex_q  <= hex_d;
    end
  end

  assign pnl.cpu_ce  = ce_q;
  assign pnl.hex_seg = hex_q;

endmodule

// File: tb/tb_seg7_disp_ctrl.sv
// Self-checking bench for seg7_disp_ctrl (6 digits, DIV_MAX=4, DB_CYCLES=3).
module tb_seg7_disp_ctrl;

  localparam int ND   = 6;
  localparam int DIVM = 4;
  localparam int DBC  = 3;

  localparam logic [6:0] TB_SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_disp_ctrl_if #(.NUM_DIGITS(ND)) pnl();

  seg7_disp_ctrl #(
    .NUM_DIGITS (ND),
    .DIV_MAX    (DIVM),
    .DIV_W      (3),
    .DB_CYCLES  (DBC),
    .DB_W       (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .pnl (pnl)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Display expected for a snapshot value, from the digit/blanking rules.
  function automatic logic [41:0] model_disp(input logic [23:0] v, input bit blz);
    logic [41:0] r;
    r = '0;
    for (int k = 0; k < ND; k++) begin
      if (blz && k > 0 && (v >> (4 * k)) == 24'd0) r[7*k +: 7] = 7'b1111111;
      else                                         r[7*k +: 7] = TB_SEG[v[4*k +: 4]];
    end
    return r;
  endfunction

  // ---------------- reference model ----------------
  // n_m: clock edges since reset; the tick falls in every DIVM-th cycle.
  // The button is seen DBC samples late through a 2-cycle synchroniser; a
  // new level is taken once the last DBC samples all disagree with it.
  int unsigned n_m = 0;
  bit          ce_m = 0, pulse_m = 0, lvl_m = 0, push_pend_m = 0;
  bit          btn_h1_m = 0, btn_h2_m = 0, rst_m = 1;
  bit          samp_m[$];
  logic [23:0] snap_m = '0;
  logic [41:0] exp_q[$];

  always @(posedge clk) begin
    bit all_flip;
    rst_m = rst;
    if (rst) begin
      n_m = 0; ce_m = 0; pulse_m = 0; lvl_m = 0; push_pend_m = 0;
      btn_h1_m = 0; btn_h2_m = 0; snap_m = '0;
      samp_m.delete();
      exp_q.delete();
    end else begin
      if (push_pend_m) exp_q.push_back(model_disp(snap_m, pnl.blank_lz));
      push_pend_m = ce_m;
      if (ce_m) snap_m = pnl.value;
      samp_m.push_back(btn_h2_m);
      if (samp_m.size() > DBC) void'(samp_m.pop_front());
      all_flip = (samp_m.size() == DBC);
      foreach (samp_m[j]) if (samp_m[j] == lvl_m) all_flip = 0;
      ce_m = pnl.run_en ? ((n_m % DIVM) == DIVM - 1) : pulse_m;
      pulse_m = 0;
      if (all_flip) begin
        lvl_m   = !lvl_m;
        pulse_m = lvl_m;
      end
      btn_h2_m = btn_h1_m;
      btn_h1_m = pnl.step_btn;
      n_m++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit mon_d1 = 0, mon_d2 = 0;
  always @(negedge clk) begin
    logic [41:0] e;
    chk("cpu_ce", {63'd0, pnl.cpu_ce}, {63'd0, ce_m});
    if (rst_m) begin
      mon_d1 = 0;
      mon_d2 = 0;
    end else begin
      if (mon_d2) begin
        if (exp_q.size() == 0) begin
          chk("hex_unexpected_update", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("hex_after_ce", {22'd0, pnl.hex_seg}, {22'd0, e});
        end
      end
      mon_d2 = mon_d1;
      mon_d1 = pnl.cpu_ce;
    end
  end

  // ---------------- drivers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hi, input int lo);
    pnl.step_btn = 1'b1;
    cycles(hi);
    pnl.step_btn = 1'b0;
    cycles(lo);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ce_cnt, ce_at, hold;
    bit          found;
    bit [0:23]   pat;
    logic [19:0] up;
    logic [41:0] tmp;

    pnl.run_en   = 1'b0;
    pnl.step_btn = 1'b0;
    pnl.blank_lz = 1'b0;
    pnl.value    = 24'hFFFFFF;

    // 1 reset
    cycles(2);
    chk("reset_ce", {63'd0, pnl.cpu_ce}, 64'd0);
    chk("reset_hex", {22'd0, pnl.hex_seg}, {22'd0, {6{7'b0000001}}});

    // 2 free run
    rst          = 1'b0;
    pnl.run_en   = 1'b1;
    pnl.value    = 24'h123ABC;
    ce_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pnl.cpu_ce) ce_cnt++;
    end
    chk("run_ce_count", 64'(ce_cnt), 64'd10);
    chk("run_hex_123abc", {22'd0, pnl.hex_seg},
        {22'd0, 7'b1001111, 7'b0010010, 7'b0000110, 7'b0001000, 7'b1100000, 7'b0110001});

    // 3 blanking
    pnl.blank_lz = 1'b1;
    pnl.value    = 24'h000012;
    cycles(8);
    chk("blank_000012", {22'd0, pnl.hex_seg},
        {22'd0, {4{7'b1111111}}, 7'b1001111, 7'b0010010});
    pnl.value = 24'h0;
    cycles(8);
    chk("blank_zero", {22'd0, pnl.hex_seg}, {22'd0, {5{7'b1111111}}, 7'b0000001});
    pnl.blank_lz = 1'b0;
    cycles(1);
    chk("blank_off_1cyc", {22'd0, pnl.hex_seg}, {22'd0, {6{7'b0000001}}});
    pnl.blank_lz = 1'b1;
    cycles(1);
    chk("blank_on_1cyc", {22'd0, pnl.hex_seg}, {22'd0, {5{7'b1111111}}, 7'b0000001});

    // 4 single step with bounce
    pnl.run_en = 1'b0;
    cycles(6);
    pat = 24'b1010_1111111111_0000000000;
    ce_cnt = 0;
    ce_at  = -1;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      if (pnl.cpu_ce) begin
        ce_cnt++;
        ce_at = i;
      end
      pnl.step_btn = (i < 24) ? pat[i] : 1'b0;
    end
    chk("step_ce_count", 64'(ce_cnt), 64'd1);
    chk("step_latency", 64'(ce_at), 64'd10);

    // 5a run_en dropped in the tick cycle
    pnl.run_en = 1'b1;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if ((n_m % DIVM) == DIVM - 1) found = 1;
    end
    chk("tick_found", {63'd0, found}, 64'd1);
    pnl.run_en = 1'b0;
    ce_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (pnl.cpu_ce) ce_cnt++;
    end
    chk("switch_no_ce", 64'(ce_cnt), 64'd0);

    // 5b reset during the 2nd stable debounce sample
    cycles(6);
    pnl.step_btn = 1'b1;
    cycles(3);
    rst          = 1'b1;
    pnl.step_btn = 1'b0;
    cycles(1);
    rst = 1'b0;
    chk("midrst_hex", {22'd0, pnl.hex_seg}, {22'd0, {6{7'b0000001}}});
    ce_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (pnl.cpu_ce) ce_cnt++;
    end
    chk("midrst_no_ce", 64'(ce_cnt), 64'd0);

    // 6 sweep digit 0 through all codes
    pnl.blank_lz = 1'b0;
    up = 20'($urandom()) | 20'h10000;
    tmp = model_disp({up, 4'h0}, 1'b0);
    for (int v = 0; v < 16; v++) begin
      pnl.value = {up, 4'(v)};
      press(8, 8);
      chk("sweep_digit0", {57'd0, pnl.hex_seg[6:0]}, {57'd0, TB_SEG[v]});
      chk("sweep_upper", {29'd0, pnl.hex_seg[41:7]}, {29'd0, tmp[41:7]});
    end

    // random mix
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      pnl.value = 24'($urandom()) >> (4 * $urandom_range(0, 6));
      if (hold == 0) begin
        pnl.step_btn = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 19) == 0) pnl.run_en = !pnl.run_en;
      if ($urandom_range(0, 15) == 0) pnl.blank_lz = !pnl.blank_lz;
    end
    pnl.run_en   = 1'b0;
    pnl.step_btn = 1'b0;
    cycles(20);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
